// File: rtl/object_move_if.sv
// Control/position bus for object_move: flight commands and velocity in,
// whole-pixel position and flight status out.
interface object_move_if;
    logic       moveclk;
    logic       launch;
    logic       kill;
    logic [9:0] initx;
    logic [8:0] inity;
    logic [9:0] vx;
    logic [8:0] vy;
    logic [1:0] vdx;
    logic [1:0] vdy;
    logic [9:0] x;
    logic [8:0] y;
    logic       active;
    logic       exited;

    modport master (
        output moveclk, launch, kill, initx, inity, vx, vy, vdx, vdy,
        input  x, y, active, exited
    );
    modport slave (
        input  moveclk, launch, kill, initx, inity, vx, vy, vdx, vdy,
        output x, y, active, exited
    );
endinterface

// File: rtl/object_move.sv
// Sub-pixel object flight: launch, per-tick velocity integration, exit detection
// at left/right/bottom edges, clamping at the top edge.
module object_move #(
    parameter int XMAX = 640,
    parameter int YMAX = 480,
    parameter int FRAC = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    object_move_if.slave bus
);
    localparam int PXW = 10 + FRAC;
    localparam int PYW = 9 + FRAC;
    localparam logic [10:0] XLIM = 11'(XMAX);
    localparam logic [9:0]  YLIM = 10'(YMAX);

    typedef enum logic [1:0] {IDLE, FLY, EXIT} state_t;

    state_t         state_q;
    logic [PXW-1:0] px_q, px_d;
    logic [PYW-1:0] py_q, py_d;
    logic [PXW:0]   xsum;
    logic [PYW:0]   ysum;
    logic           xexit, yexit;

    assign xsum = {1'b0, px_q} + (PXW+1)'(bus.vx);
    assign ysum = {1'b0, py_q} + (PYW+1)'(bus.vy);

    // Candidate positions for this tick; only committed if neither axis exits.
    always_comb begin
        xexit = 1'b0;
        yexit = 1'b0;
        px_d  = px_q;
        py_d  = py_q;
        if (bus.vdx[1]) begin
            if (bus.vdx[0]) begin
                if (xsum[PXW] || ({1'b0, xsum[PXW-1:FRAC]} >= XLIM)) xexit = 1'b1;
                else px_d = xsum[PXW-1:0];
            end else begin
                if (PXW'(bus.vx) > px_q) xexit = 1'b1;
                else px_d = px_q - PXW'(bus.vx);
            end
        end
        if (bus.vdy[1]) begin
            if (bus.vdy[0]) begin
                if (ysum[PYW] || ({1'b0, ysum[PYW-1:FRAC]} >= YLIM)) yexit = 1'b1;
                else py_d = ysum[PYW-1:0];
            end else begin
                // Top edge clamps rather than ending the flight.
                if (PYW'(bus.vy) > py_q) py_d = '0;
                else py_d = py_q - PYW'(bus.vy);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
        end else if (bus.launch) begin
            state_q <= FLY;
            px_q    <= {bus.initx, {FRAC{1'b0}}};
            py_q    <= {bus.inity, {FRAC{1'b0}}};
        end else begin
            case (state_q)
                FLY: begin
                    if (bus.kill) begin
                        state_q <= IDLE;
                    end else if (bus.moveclk) begin
                        if (xexit || yexit) begin
                            state_q <= EXIT;
                        end else begin
                            px_q <= px_d;
                            py_q <= py_d;
                        end
                    end
                end
                EXIT:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x      = px_q[PXW-1:FRAC];
    assign bus.y      = py_q[PYW-1:FRAC];
    assign bus.active = (state_q == FLY);
    assign bus.exited = (state_q == EXIT);
endmodule

// File: tb/tb_object_move.sv
// Directed bench for object_move with hand-computed expectations.
module tb_object_move;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    logic seen_exit;

    object_move_if bus ();

    object_move #(.XMAX(640), .YMAX(480), .FRAC(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.moveclk = 0; bus.launch = 0; bus.kill = 0;
        bus.vdx = 2'b00; bus.vdy = 2'b00;
        bus.vx = 0; bus.vy = 0;
    endtask

    task automatic do_launch(input int ix, input int iy);
        bus.launch = 1; bus.initx = 10'(ix); bus.inity = 9'(iy);
        tick();
        bus.launch = 0;
    endtask

    initial begin
        idle_in();
        bus.initx = 0; bus.inity = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_exited", bus.exited, 0);

        // 32 sub-pixels per tick = 2 px
        do_launch(100, 400);
        chk("launch_x", bus.x, 100);
        chk("launch_y", bus.y, 400);
        chk("launch_active", bus.active, 1);
        bus.vx = 32; bus.vdx = 2'b11; bus.vy = 0; bus.vdy = 2'b00;
        bus.moveclk = 1;
        repeat (3) tick();
        bus.moveclk = 0;
        chk("mv3_x", bus.x, 106);
        chk("mv3_y", bus.y, 400);
        chk("mv3_active", bus.active, 1);

        // sub-pixel accumulation
        do_launch(10, 50);
        bus.vx = 1; bus.vdx = 2'b11;
        bus.moveclk = 1;
        repeat (15) tick();
        chk("frac15_x", bus.x, 10);
        tick();
        chk("frac16_x", bus.x, 11);
        bus.moveclk = 0;

        // left-edge exit
        do_launch(1, 50);
        bus.vx = 32; bus.vdx = 2'b10;
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("lexit_pulse", bus.exited, 1);
        chk("lexit_x", bus.x, 1);
        chk("lexit_active", bus.active, 0);
        tick();
        chk("lexit_pulse_end", bus.exited, 0);
        chk("lexit_idle", bus.active, 0);

        // top-edge clamp, no exit
        do_launch(5, 0);
        bus.vdx = 2'b00; bus.vy = 16; bus.vdy = 2'b10;
        seen_exit = 0;
        bus.moveclk = 1;
        repeat (4) begin tick(); seen_exit |= bus.exited; end
        bus.moveclk = 0;
        chk("top_y", bus.y, 0);
        chk("top_active", bus.active, 1);
        chk("top_noexit", seen_exit, 0);

        // y decrement / increment inside bounds
        do_launch(5, 100);
        bus.vy = 32; bus.vdy = 2'b10;
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("ydec_y", bus.y, 98);
        do_launch(5, 470);
        bus.vy = 32; bus.vdy = 2'b11;
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("yinc_y", bus.y, 472);

        // bottom-edge exit
        do_launch(5, 479);
        bus.vy = 16; bus.vdy = 2'b11;
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("bexit_pulse", bus.exited, 1);
        chk("bexit_y", bus.y, 479);
        tick();

        // y exit blocks the x commit on the same tick
        do_launch(100, 479);
        bus.vx = 32; bus.vdx = 2'b11; bus.vy = 16; bus.vdy = 2'b11;
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("bothexit_pulse", bus.exited, 1);
        chk("bothexit_x", bus.x, 100);
        tick();

        // launch with moveclk: no movement
        bus.vx = 32; bus.vdx = 2'b11; bus.vdy = 2'b00;
        bus.moveclk = 1;
        do_launch(200, 100);
        bus.moveclk = 0;
        chk("lmv_x", bus.x, 200);
        chk("lmv_active", bus.active, 1);

        // kill with moveclk: IDLE, position held, no pulse
        bus.kill = 1; bus.moveclk = 1; tick();
        bus.kill = 0; bus.moveclk = 0;
        chk("kill_active", bus.active, 0);
        chk("kill_exited", bus.exited, 0);
        chk("kill_x", bus.x, 200);
        tick();
        chk("kill_exited2", bus.exited, 0);
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("idle_mv_x", bus.x, 200);

        // right-edge exit, relaunch during the EXIT cycle
        do_launch(639, 10);
        bus.vx = 16; bus.vdx = 2'b11; bus.vdy = 2'b00;
        bus.moveclk = 1; tick(); bus.moveclk = 0;
        chk("rexit_pulse", bus.exited, 1);
        chk("rexit_x", bus.x, 639);
        do_launch(20, 30);
        chk("relaunch_active", bus.active, 1);
        chk("relaunch_exited", bus.exited, 0);
        chk("relaunch_x", bus.x, 20);

        // reset mid-flight, launch alongside ignored
        do_launch(300, 200);
        chk("pre_rst_x", bus.x, 300);
        rst = 1; bus.launch = 1; bus.initx = 5; bus.moveclk = 1;
        tick();
        rst = 0; bus.launch = 0;
        chk("mrst_x", bus.x, 0);
        chk("mrst_y", bus.y, 0);
        chk("mrst_active", bus.active, 0);
        chk("mrst_exited", bus.exited, 0);
        tick();
        bus.moveclk = 0;
        chk("post_rst_x", bus.x, 0);
        chk("post_rst_active", bus.active, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/object_move.md
OBJECT_MOVE -- requirements
Module: object_move

Interface
REQ-001 Parameter XMAX, default 640, exclusive right screen bound in whole pixels.
REQ-002 Parameter YMAX, default 480, exclusive bottom screen bound in whole pixels.
REQ-003 Parameter FRAC, default 4, count of sub-pixel fraction bits; velocity unit is 1/2^FRAC pixel per tick.
REQ-004 clk  input  1  single system clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 moveclk  input  1  one-clk-wide movement tick enable.
REQ-007 launch  input  1  start or restart flight; loads initx/inity.
REQ-008 kill  input  1  abort flight (object sliced); no exit pulse.
REQ-009 initx  input  10  launch x, whole pixels.
REQ-010 inity  input  9  launch y, whole pixels.
REQ-011 vx  input  10  x speed magnitude, sub-pixel units.
REQ-012 vy  input  9  y speed magnitude, sub-pixel units.
REQ-013 vdx  input  2  x direction: bit1 = moving enable, bit0 = 1 increment / 0 decrement.
REQ-014 vdy  input  2  y direction, same encoding as vdx; y increment means downward.
REQ-015 x  output  10  registered whole-pixel x position.
REQ-016 y  output  9  registered whole-pixel y position.
REQ-017 active  output  1  high while state is FLY.
REQ-018 exited  output  1  one-clk pulse when the object leaves the screen.

Function
REQ-019 Internal position registers: px = 10+FRAC bits, py = 9+FRAC bits; x = px integer field, y = py integer field.
REQ-020 States: IDLE, FLY, EXIT; active = (state==FLY), exited = (state==EXIT).
REQ-021 Priority per cycle: rst > launch > kill > moveclk.
REQ-022 launch in any state: px = initx<<FRAC, py = inity<<FRAC, state -> FLY; no movement in that cycle even if moveclk high.
REQ-023 kill in FLY (without launch): state -> IDLE next cycle, position held, exited stays 0; kill ignored in IDLE/EXIT.
REQ-024 moveclk in FLY: x and y axes update in the same cycle, independently.
REQ-025 Axis with vd[1]=0: position unchanged.
REQ-026 x increment: sum = px + vx, computed one bit wider than px; if carry out or integer field of sum >= XMAX -> exit, else px = sum.
REQ-027 x decrement: if vx > px -> exit, else px = px - vx.
REQ-028 y increment: sum = py + vy, one bit wider than py; if carry out or integer field >= YMAX -> exit, else py = sum.
REQ-029 y decrement: if vy > py -> py = 0 and flight continues (top edge clamps, no exit), else py = py - vy.
REQ-030 Exit from either axis: state -> EXIT; px/py hold last in-bounds value (neither axis commits on that tick).
REQ-031 EXIT lasts exactly one clk, then IDLE unless launch is asserted that cycle.
REQ-032 moveclk in IDLE or EXIT: no effect.
REQ-033 Velocity inputs sampled only on moveclk in FLY; no internal velocity state.

Reset
REQ-034 rst: state = IDLE, px = 0, py = 0, hence x = 0, y = 0, active = 0, exited = 0.
REQ-035 rst mid-flight or during EXIT aborts with no exited pulse; launch with rst is ignored.

Verification
REQ-036 launch initx=100 inity=400; vx=32 vdx=2'b11, vy=0 vdy=2'b00; 3 moveclk -> x=106, y=400, active=1.
REQ-037 vx=1 vdx=2'b11 from x=10 -> x stays 10 through 15 ticks, becomes 11 on 16th tick.
REQ-038 initx=1, vx=32 vdx=2'b10, moveclk -> exited=1 one clk, x=1 held, then active=0.
REQ-039 inity=0, vy=16 vdy=2'b10, 4 ticks -> y=0, active=1, exited never asserted; inity=479 vy=16 vdy=2'b11 tick -> exited pulse, y=479.
REQ-040 launch and moveclk same cycle -> position equals init, no movement; kill and moveclk same cycle in FLY -> IDLE, no exited.
REQ-041 rst asserted mid-flight at x=300 -> next cycle x=0, y=0, active=0, exited=0; subsequent moveclk has no effect.
